// File: rtl/sm_clk_ctrl_pkg.sv
// Shared encodings for the CPU clock controller: mode codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sm_clk_ctrl_pkg;

  // Operator mode switch encodings; 2'b11 is reserved and behaves as halt.
  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // Clock generator phases.
  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_HIGH = 2'b01,
    S_LOW  = 2'b10
  } state_t;

  // Free-running mode: periods keep starting without a step request.
  function automatic logic mode_is_run(input logic [1:0] m);
    return (m == MODE_RUN);
  endfunction

  // Single-step mode: step button edges are accepted.
  function automatic logic mode_is_step(input logic [1:0] m);
    return (m == MODE_STEP);
  endfunction

endpackage

// File: rtl/sm_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse after a 0->1 transition of i_sig.
// Latency: pulse appears one clock after the input is seen high.
// Backpressure: none; the pulse is not held and must be consumed in its cycle.
module sm_rise_detect
  import sm_clk_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // History flop tracks the input even during reset so a level held across reset is not a fresh edge.
  always_ff @(posedge i_clk) begin
    r_prev <= i_sig;
  end

  // Edge pulse register, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rise <= 1'b0;
    end else begin
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock generator: glitch-free 50% divided clock with run/halt/single-step and a tick counter.
// Latency: inputs pass 2-flop synchronizers; a new period starts the cycle after go is seen.
// Backpressure: none; a halt lets the current period finish, one step request may be queued.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int SHIFT = 16,
  parameter int DIV_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divide,
  input  logic [1:0]       mode,
  input  logic             stepReq,
  output logic             clkOut,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cycles
);

  // Prescaler is wide enough for the largest half-period exponent SHIFT + 2^DIV_W - 1.
  localparam int PRE_W = SHIFT + 2**DIV_W;

  logic [DIV_W-1:0] r_div_m;
  logic [DIV_W-1:0] r_div_s;
  logic [1:0]       r_mode_m;
  logic [1:0]       r_mode_s;
  logic             r_step_m;
  logic             r_step_s;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div_l;
  logic             r_step_pend;
  logic             r_clk;
  logic             r_tick;
  logic             r_busy;
  logic [CNT_W-1:0] r_cycles;

  logic             w_step_rise;
  logic [PRE_W-1:0] w_half;
  logic             w_last;
  logic             w_go;
  logic             w_rise;

  // Two-flop synchronizers; left out of reset so a held mode setting survives a reset pulse.
  always_ff @(posedge clkIn) begin
    r_div_m  <= divide;
    r_div_s  <= r_div_m;
    r_mode_m <= mode;
    r_mode_s <= r_mode_m;
    r_step_m <= stepReq;
    r_step_s <= r_step_m;
  end

  sm_rise_detect u_step_rise (
    .i_clk   (clkIn),
    .i_rst_n (rst_n),
    .i_sig   (r_step_s),
    .o_rise  (w_step_rise)
  );

  // Half-period end detect and period start decision; the divide used is the one latched at the last rise.
  always_comb begin
    w_half = PRE_W'(1) << (SHIFT + int'(r_div_l));
    w_last = (r_pre == (w_half - PRE_W'(1)));
    w_go   = mode_is_run(r_mode_s) | r_step_pend;
    w_rise = w_go & ((r_state == S_HALT) | ((r_state == S_LOW) & w_last));
  end

  // One-deep step queue: a request and a consume in the same cycle leave it pending; leaving step mode flushes it.
  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      r_step_pend <= 1'b0;
    end else if (!mode_is_step(r_mode_s)) begin
      r_step_pend <= 1'b0;
    end else if (w_step_rise) begin
      r_step_pend <= 1'b1;
    end else if (w_rise) begin
      r_step_pend <= 1'b0;
    end
  end

  // Clock FSM with prescaler and rise counter; all outputs registered, a halt only takes effect at a period end.
  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      r_state  <= S_HALT;
      r_pre    <= '0;
      r_div_l  <= '0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_tick <= 1'b0;
      if (w_rise) begin
        r_state  <= S_HIGH;
        r_pre    <= '0;
        r_div_l  <= r_div_s;
        r_clk    <= 1'b1;
        r_tick   <= 1'b1;
        r_busy   <= 1'b1;
        r_cycles <= r_cycles + CNT_W'(1);
      end else begin
        case (r_state)
          S_HALT: begin
            r_pre  <= '0;
            r_clk  <= 1'b0;
            r_busy <= 1'b0;
          end
          S_HIGH: begin
            if (w_last) begin
              r_pre   <= '0;
              r_clk   <= 1'b0;
              r_state <= S_LOW;
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          S_LOW: begin
            if (w_last) begin
              r_pre   <= '0;
              r_state <= S_HALT;
              r_busy  <= 1'b0;
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          default: begin
            r_state <= S_HALT;
            r_pre   <= '0;
            r_clk   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clkOut = r_clk;
  assign tick   = r_tick;
  assign busy   = r_busy;
  assign cycles = r_cycles;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Bench for sm_clk_ctrl: directed scenarios then random mode/divide/step/reset traffic.
// Outputs are compared every cycle against a timeline model of periods.
// Small parameters keep periods short.
module tb_sm_clk_ctrl;
  localparam int SHIFT = 1;
  localparam int DIV_W = 2;
  localparam int CNT_W = 4;
  localparam int HMAX  = 16384;

  logic             clkIn   = 1'b0;
  logic             rst_n   = 1'b0;
  logic [DIV_W-1:0] divide  = '0;
  logic [1:0]       mode    = 2'b00;
  logic             stepReq = 1'b0;
  logic             clkOut;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cycles;

  sm_clk_ctrl #(.SHIFT(SHIFT), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clkIn   (clkIn),
    .rst_n   (rst_n),
    .divide  (divide),
    .mode    (mode),
    .stepReq (stepReq),
    .clkOut  (clkOut),
    .tick    (tick),
    .busy    (busy),
    .cycles  (cycles)
  );

  always #5 clkIn = ~clkIn;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Input values present at each clock edge.
  logic [1:0]       h_mode [HMAX];
  logic [DIV_W-1:0] h_div  [HMAX];
  logic             h_step [HMAX];
  logic             h_rst  [HMAX];

  // Model: a period starting at edge m_start with half length m_half is high for m_half edges then low for m_half.
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_half   = 1;
  bit m_pend   = 1'b0;
  int m_rises  = 0;
  bit e_clk, e_tick, e_busy;
  logic [CNT_W-1:0] e_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, expv, edge_n);
    end
  endtask

  task automatic model_edge();
    int e;
    logic [1:0] ms;
    logic [DIV_W-1:0] ds;
    bit go, pulse, decide;
    e = edge_n;
    h_mode[e] = mode;
    h_div[e]  = divide;
    h_step[e] = stepReq;
    h_rst[e]  = rst_n;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_rises  = 0;
    end else begin
      // Synchronized inputs lag two edges; the step edge pulse lags one more.
      ms     = (e >= 3) ? h_mode[e-2] : 2'b00;
      ds     = (e >= 3) ? h_div[e-2] : '0;
      pulse  = (e >= 5) && (h_rst[e-1] === 1'b1) && (h_step[e-3] === 1'b1) && (h_step[e-4] === 1'b0);
      go     = (ms == 2'b01) || m_pend;
      decide = !m_active || ((e - m_start) == 2 * m_half);
      if (ms != 2'b10) m_pend = 1'b0;
      else if (pulse) m_pend = 1'b1;
      else if (decide && go) m_pend = 1'b0;
      if (decide) begin
        if (go) begin
          m_active = 1'b1;
          m_start  = e;
          m_half   = 1 << (SHIFT + int'(ds));
          m_rises++;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    e_clk    = m_active && ((e - m_start) < m_half);
    e_tick   = m_active && (e == m_start);
    e_busy   = m_active;
    e_cycles = CNT_W'(m_rises % (1 << CNT_W));
  endtask

  task automatic cyc();
    @(posedge clkIn);
    edge_n++;
    if (edge_n >= HMAX) begin
      $display("FAIL history_overflow: edge %0d exceeds %0d", edge_n, HMAX);
      $fatal(1, "history overflow");
    end
    model_edge();
    #1;
    chk("clkOut", 32'(clkOut), 32'(e_clk));
    chk("tick",   32'(tick),   32'(e_tick));
    chk("busy",   32'(busy),   32'(e_busy));
    chk("cycles", 32'(cycles), 32'(e_cycles));
  endtask

  task automatic cyc_n(input int n, output int ticks, output int rises);
    logic prev;
    prev  = clkOut;
    ticks = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (tick === 1'b1) ticks++;
      if (clkOut === 1'b1 && prev === 1'b0) rises++;
      prev = clkOut;
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 100);
    chk(tag, 32'(tick), 32'(1));
  endtask

  task automatic meas_high(input string tag, output int len);
    wait_tick(tag);
    len = 1;
    while (len < 100) begin
      cyc();
      if (clkOut !== 1'b1) break;
      len++;
    end
  endtask

  initial begin
    int n, tk, rs, len, base;

    // Reset with the switches at halt.
    repeat (6) cyc();
    chk("rst_clkOut", 32'(clkOut), 32'(0));
    chk("rst_tick",   32'(tick),   32'(0));
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_cycles", 32'(cycles), 32'(0));

    // Release reset and select RUN together: first rise on the third edge.
    rst_n = 1'b1;
    mode  = 2'b01;
    n = 0;
    do begin
      cyc();
      n++;
    end while (clkOut !== 1'b1 && n < 20);
    chk("s1_first_rise_edge", 32'(n), 32'(3));
    cyc_n(16, tk, rs);
    chk("s1_ticks", 32'(tk), 32'(4));
    chk("s1_cycles", 32'(cycles), 32'(5));

    // Divide change during HIGH only takes effect at the next rise.
    wait_tick("s2_tick");
    cyc();
    divide = 2'd2;
    meas_high("s2_tick2", len);
    chk("s2_high_len", 32'(len), 32'(8));

    // Halt requested in the first high cycle: the period completes, then stays low.
    divide = 2'd1;
    meas_high("s3_tick", len);
    chk("s3_high_len", 32'(len), 32'(4));
    wait_tick("s3_tick2");
    mode = 2'b00;
    base = m_rises;
    cyc_n(20, tk, rs);
    chk("s3_no_more_ticks", 32'(tk), 32'(0));
    chk("s3_busy", 32'(busy), 32'(0));
    chk("s3_frozen", 32'(cycles), 32'(base % 16));

    // Single step: one pulse gives one period.
    mode   = 2'b10;
    divide = 2'd0;
    repeat (8) cyc();
    base = m_rises;
    stepReq = 1'b1;
    cyc();
    stepReq = 1'b0;
    cyc_n(14, tk, rs);
    chk("s4_one_tick", 32'(tk), 32'(1));
    chk("s4_one_cycles", 32'(cycles), 32'((base + 1) % 16));
    chk("s4_one_busy", 32'(busy), 32'(0));

    // Edges two cycles apart run back to back; a third while pending is dropped.
    base = m_rises;
    for (int i = 0; i < 3; i++) begin
      stepReq = 1'b1;
      cyc();
      stepReq = 1'b0;
      cyc();
    end
    cyc_n(20, tk, rs);
    chk("s4_two_cycles", 32'(cycles), 32'((base + 2) % 16));
    chk("s4_two_busy", 32'(busy), 32'(0));

    // Reset mid-HIGH aborts; RUN held in the synchronizers restarts at once.
    mode = 2'b01;
    repeat (3) cyc();
    wait_tick("s5_tick");
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("s5_rst_clkOut", 32'(clkOut), 32'(0));
    chk("s5_rst_tick",   32'(tick),   32'(0));
    chk("s5_rst_busy",   32'(busy),   32'(0));
    chk("s5_rst_cycles", 32'(cycles), 32'(0));
    rst_n = 1'b1;
    cyc();
    chk("s5_restart_clkOut", 32'(clkOut), 32'(1));
    chk("s5_restart_cycles", 32'(cycles), 32'(1));

    // Seventeen more rises wrap the 4-bit counter from 1 through 15, 0, 1 to 2.
    cyc_n(68, tk, rs);
    chk("s6_ticks", 32'(tk), 32'(17));
    chk("s6_rises", 32'(rs), 32'(17));
    chk("s6_cycles_wrap", 32'(cycles), 32'(2));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) divide = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) stepReq = ~stepReq;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
